// File: rtl/dvs_event_decoder.sv
// Byte-stream parser for DVS sensor events arriving over UART.
// Decodes 5-byte packets into a FWFT event FIFO and recognises single-byte commands.
`timescale 1ns/1ps
module dvs_event_decoder #(
  parameter int unsigned SENSOR_RES          = 320,
  parameter int unsigned FIFO_DEPTH          = 8,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [8:0]  event_x,
  output logic [8:0]  event_y,
  output logic        event_polarity,
  output logic [15:0] event_ts,
  output logic        cmd_echo,
  output logic        cmd_status,
  output logic        cmd_config,
  output logic        cmd_soft_rst,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [7:0]  drop_count,
  output logic [7:0]  err_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(BYTE_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StXHi, StXLo, StYHi, StYLo, StPol} state_e;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [15:0] ts;
  } event_t;

  state_e         state_q;
  logic [8:0]     x_q, y_q;
  logic [TW-1:0]  timer_q;
  logic [15:0]    ts_q;

  event_t         mem [FIFO_DEPTH];
  event_t         head;
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AW:0]    cnt_q;

  logic pkt_done, range_err, timeout, push, drop, pop, err_inc;

  always_comb begin
    pkt_done  = rx_valid && (state_q == StPol);
    range_err = ({23'd0, x_q} >= SENSOR_RES) || ({23'd0, y_q} >= SENSOR_RES);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    timeout   = (state_q != StXHi) && !rx_valid && (timer_q == TW'(BYTE_TIMEOUT_CYCLES));
    push      = pkt_done && !range_err && !fifo_full;
    drop      = pkt_done && !range_err && fifo_full;
    err_inc   = (pkt_done && range_err) || timeout;
    pop       = event_valid && event_ready;
  end

  // Parser FSM, timestamp, inter-byte timer and registered command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StXHi;
      x_q          <= '0;
      y_q          <= '0;
      timer_q      <= '0;
      ts_q         <= '0;
      cmd_echo     <= 1'b0;
      cmd_status   <= 1'b0;
      cmd_config   <= 1'b0;
      cmd_soft_rst <= 1'b0;
    end else begin
      ts_q         <= ts_q + 16'd1;
      cmd_echo     <= 1'b0;
      cmd_status   <= 1'b0;
      cmd_config   <= 1'b0;
      cmd_soft_rst <= 1'b0;
      if (rx_valid) begin
        timer_q <= '0;
        unique case (state_q)
          StXHi: begin
            if (rx_data >= 8'hFC) begin
              cmd_echo     <= (rx_data == 8'hFF);
              cmd_status   <= (rx_data == 8'hFE);
              cmd_config   <= (rx_data == 8'hFD);
              cmd_soft_rst <= (rx_data == 8'hFC);
            end else begin
              x_q[8]  <= rx_data[0];
              state_q <= StXLo;
            end
          end
          StXLo: begin
            x_q[7:0] <= rx_data;
            state_q  <= StYHi;
          end
          StYHi: begin
            y_q[8]  <= rx_data[0];
            state_q <= StYLo;
          end
          StYLo: begin
            y_q[7:0] <= rx_data;
            state_q  <= StPol;
          end
          default: state_q <= StXHi;
        endcase
      end else if (timeout) begin
        state_q <= StXHi;
        timer_q <= '0;
      end else if (state_q != StXHi) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{x: x_q, y: y_q, pol: rx_data[0], ts: ts_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (drop && drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
      if (err_inc && err_count != 8'hFF) err_count  <= err_count + 8'd1;
    end
  end

  always_comb begin
    fifo_full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty     = (cnt_q == '0);
    event_valid    = !fifo_empty;
    head           = mem[rd_ptr_q];
    event_x        = fifo_empty ? 9'd0  : head.x;
    event_y        = fifo_empty ? 9'd0  : head.y;
    event_polarity = fifo_empty ? 1'b0  : head.pol;
    event_ts       = fifo_empty ? 16'd0 : head.ts;
  end

endmodule

// File: tb/tb_dvs_event_decoder.sv
// Directed bench for dvs_event_decoder: packets, commands, range errors,
// byte timeout, FIFO overflow/stall and asynchronous reset.
`timescale 1ns/1ps
module tb_dvs_event_decoder;

  localparam int unsigned RES   = 320;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        event_ready = 1'b1;
  logic        event_valid, event_polarity;
  logic [8:0]  event_x, event_y;
  logic [15:0] event_ts;
  logic        cmd_echo, cmd_status, cmd_config, cmd_soft_rst;
  logic        fifo_full, fifo_empty;
  logic [7:0]  drop_count, err_count;

  dvs_event_decoder #(
    .SENSOR_RES(RES),
    .FIFO_DEPTH(DEPTH),
    .BYTE_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .event_valid(event_valid), .event_ready(event_ready), .event_x(event_x),
    .event_y(event_y), .event_polarity(event_polarity), .event_ts(event_ts),
    .cmd_echo(cmd_echo), .cmd_status(cmd_status), .cmd_config(cmd_config),
    .cmd_soft_rst(cmd_soft_rst), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .drop_count(drop_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cmd  = 0;
  logic [15:0] stamp;
  logic [15:0] last_ts;
  logic [15:0] fill_ts [DEPTH];

  // Reference timestamp: rising edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp <= 16'd0;
    else        stamp <= stamp + 16'd1;
  end

  always @(negedge clk) begin
    if (cmd_echo || cmd_status || cmd_config || cmd_soft_rst) n_cmd++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    last_ts  = stamp;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic send_pkt(input logic [8:0] x, input logic [8:0] y, input logic p);
    send5({7'd0, x[8]}, x[7:0], {7'd0, y[8]}, y[7:0], {7'd0, p});
  endtask

  task automatic check_head(input string tag, input logic [8:0] x, input logic [8:0] y,
                            input logic p, input logic [15:0] ts);
    check({tag, ".valid"}, event_valid, 1);
    check({tag, ".x"}, event_x, x);
    check({tag, ".y"}, event_y, y);
    check({tag, ".pol"}, event_polarity, p);
    check({tag, ".ts"}, event_ts, ts);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, event_valid, 0);
    check({tag, ".empty"}, fifo_empty, 1);
    check({tag, ".full"}, fifo_full, 0);
    check({tag, ".xy"}, {event_x, event_y}, 0);
    check({tag, ".pol_ts"}, {event_polarity, event_ts}, 0);
    check({tag, ".cmd"}, {cmd_echo, cmd_status, cmd_config, cmd_soft_rst}, 0);
    check({tag, ".drop"}, drop_count, 0);
    check({tag, ".err"}, err_count, 0);
  endtask

  initial begin
    int snap;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;

    // 00 64 01 2C 01 -> x=100 y=300 pol=1, popped after one cycle.
    send5(8'h00, 8'h64, 8'h01, 8'h2C, 8'h01);
    check_head("basic", 9'd100, 9'd300, 1'b1, last_ts);
    @(negedge clk);
    check("basic.pulse", event_valid, 0);

    send_byte(8'hFE);
    check("cmd_fe", {cmd_echo, cmd_status, cmd_config, cmd_soft_rst}, 4'b0100);
    @(negedge clk);
    check("cmd_fe.end", cmd_status, 0);
    snap = n_cmd;
    send5(8'h00, 8'h0A, 8'h00, 8'hFE, 8'h00);
    check_head("data_fe", 9'd10, 9'd254, 1'b0, last_ts);
    check("data_fe.nocmd", n_cmd, snap);
    @(negedge clk);

    send_byte(8'hFF);
    check("cmd_ff", {cmd_echo, cmd_status, cmd_config, cmd_soft_rst}, 4'b1000);
    send_byte(8'hFD);
    check("cmd_fd", {cmd_echo, cmd_status, cmd_config, cmd_soft_rst}, 4'b0010);
    send_byte(8'hFC);
    check("cmd_fc", {cmd_echo, cmd_status, cmd_config, cmd_soft_rst}, 4'b0001);

    // Range: x=320 and y=320 rejected, 319/319 accepted.
    send5(8'h01, 8'h40, 8'h00, 8'h05, 8'h00);
    check("range_x.valid", event_valid, 0);
    check("range_x.err", err_count, 1);
    send5(8'h00, 8'h05, 8'h01, 8'h40, 8'h00);
    check("range_y.valid", event_valid, 0);
    check("range_y.err", err_count, 2);
    send5(8'h01, 8'h3F, 8'h01, 8'h3F, 8'h01);
    check_head("edge319", 9'd319, 9'd319, 1'b1, last_ts);
    @(negedge clk);

    // 0xFC is only a pulse; counters survive it.
    send_byte(8'hFC);
    @(negedge clk);
    check("softrst.err", err_count, 2);

    // Timeout: TO idle cycles tolerated, fires on the next.
    send_byte(8'h00);
    send_byte(8'h07);
    repeat (TO) @(negedge clk);
    check("to.early", err_count, 2);
    @(negedge clk);
    check("to.fire", err_count, 3);
    send5(8'h00, 8'h0C, 8'h00, 8'h22, 8'h01);
    check_head("to.next", 9'd12, 9'd34, 1'b1, last_ts);
    @(negedge clk);

    // Byte arriving in the expiry cycle continues the packet.
    send_byte(8'h00);
    send_byte(8'h0D);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h0E);
    send_byte(8'h00);
    check("win.err", err_count, 3);
    check_head("win", 9'd13, 9'd14, 1'b0, last_ts);
    @(negedge clk);

    // Overflow with consumer stalled: DEPTH stored, 3 dropped.
    event_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      send_pkt(9'(20 + i), 9'(300 - i), i[0]);
      if (i < DEPTH) fill_ts[i] = last_ts;
    end
    check("fill.full", fifo_full, 1);
    check("fill.drop", drop_count, 3);
    check("fill.err", err_count, 3);
    repeat (3) begin
      @(negedge clk);
      check_head("stall", 9'd20, 9'd300, 1'b0, fill_ts[0]);
    end
    event_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_head("drain", 9'(20 + i), 9'(300 - i), i[0], fill_ts[i]);
      @(negedge clk);
    end
    check("drain.empty", fifo_empty, 1);
    check("drain.full", fifo_full, 0);

    // Simultaneous push and pop with one entry held.
    event_ready = 1'b0;
    send_pkt(9'd50, 9'd60, 1'b1);
    send_byte(8'h00); send_byte(8'h33); send_byte(8'h00); send_byte(8'h44);
    @(negedge clk);
    rx_data = 8'h00; rx_valid = 1'b1; event_ready = 1'b1; last_ts = stamp;
    @(negedge clk);
    rx_valid = 1'b0; event_ready = 1'b0;
    check_head("pushpop", 9'd51, 9'd68, 1'b0, last_ts);
    event_ready = 1'b1;
    @(negedge clk);
    check("pushpop.empty", fifo_empty, 1);

    // Asynchronous reset mid-packet with two events queued.
    event_ready = 1'b0;
    send_pkt(9'd1, 9'd2, 1'b0);
    send_pkt(9'd3, 9'd4, 1'b1);
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h00);
    check("pre_rst.valid", event_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1; rx_data = 8'h00; rx_valid = 1'b1; event_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    send_byte(8'h2D); send_byte(8'h01); send_byte(8'h04); send_byte(8'h00);
    check_head("post_rst", 9'd45, 9'd260, 1'b0, last_ts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_event_decoder.md
DVS_EVENT_DECODER -- requirements
Module: dvs_event_decoder

Interface
REQ-001 SHALL have parameter SENSOR_RES, default 320, exclusive upper bound for X and Y.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event buffer entries, power of two, at least 2.
REQ-003 SHALL have parameter BYTE_TIMEOUT_CYCLES, default 12000, idle cycles allowed between bytes of one packet.
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async assert, active-low reset.
REQ-005 SHALL have these ports:
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe for rx_data.
- event_valid  out  1  FIFO head valid.
- event_ready  in  1  consumer accepts head.
- event_x  out  9  head X.
- event_y  out  9  head Y.
- event_polarity  out  1  head polarity.
- event_ts  out  16  head timestamp.
- cmd_echo  out  1  pulse on 0xFF.
- cmd_status  out  1  pulse on 0xFE.
- cmd_config  out  1  pulse on 0xFD.
- cmd_soft_rst  out  1  pulse on 0xFC.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- drop_count  out  8  events lost to FIFO full, saturating.
- err_count  out  8  range errors plus timeouts, saturating.

Function
REQ-006 SHALL run a free-running 16-bit timestamp counter that increments every cycle and wraps from 0xFFFF to 0.
REQ-007 SHALL implement parser states X_HI, X_LO, Y_HI, Y_LO and POL, and SHALL advance one state per rx_valid byte.
REQ-008 In X_HI, bytes 0xFF, 0xFE, 0xFD and 0xFC SHALL each raise the matching cmd_* output for exactly one cycle, one cycle after rx_valid, and the parser SHALL stay in X_HI.
REQ-009 In X_HI, any other byte SHALL latch x[8] = rx_data[0] and move to X_LO; rx_data[7:1] SHALL be ignored.
REQ-010 Transitions in the middle of a packet:
- X_LO latches x[7:0] and moves to Y_HI.
- Y_HI latches y[8] = rx_data[0] and moves to Y_LO.
- Y_LO latches y[7:0] and moves to POL.
- Bytes 0xFC through 0xFF received mid-packet SHALL be treated as data, never as commands.
REQ-011 The POL byte SHALL complete the packet and return the parser to X_HI. The packet's polarity is rx_data[0] and its timestamp is the counter value in the POL rx_valid cycle.
REQ-012 A completed packet SHALL be resolved by exactly one of three rules:
- x >= SENSOR_RES or y >= SENSOR_RES: discard it and increment err_count.
- Otherwise, FIFO full (occupancy sampled before any same-cycle pop): discard it and increment drop_count.
- Otherwise: push it into the FIFO.
REQ-013 An inter-byte timer SHALL clear on every rx_valid and on entry to X_HI. In any state other than X_HI, when the timer reaches BYTE_TIMEOUT_CYCLES with no rx_valid, the parser SHALL return to X_HI, discard the partial packet and increment err_count.
REQ-014 If rx_valid coincides with timeout expiry, the byte SHALL win: it is processed as a continuation and no timeout is counted.
REQ-015 FIFO behaviour SHALL be first-word-fall-through:
- event_valid = !fifo_empty.
- The event_* outputs show the head entry.
- A pop occurs when event_valid && event_ready.
REQ-016 Latency: a pushed packet SHALL appear on event_valid in the cycle after its POL rx_valid when the FIFO was empty.
REQ-017 event_* outputs SHALL hold stable while event_valid=1 and event_ready=0.
REQ-018 A simultaneous push and pop on a non-full FIFO SHALL both take effect, leaving occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 drop_count and err_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-020 cmd_soft_rst SHALL only be an output; the block SHALL NOT reset itself on 0xFC.

Reset
REQ-021 While rst_n=0, the block SHALL be held in reset as follows:
- Parser in X_HI; timer and timestamp at 0.
- FIFO emptied: fifo_empty=1, fifo_full=0, event_valid=0.
- event_x, event_y, event_polarity and event_ts = 0.
- All cmd_* outputs = 0; drop_count = 0; err_count = 0.
REQ-022 Reset asserted mid-packet or with the FIFO non-empty SHALL discard all partial and buffered data immediately and asynchronously.
REQ-023 The first rx_valid byte accepted SHALL be the first rising edge after rst_n deasserts.

Verification
REQ-024 Send bytes 00 64 01 2C 01 with event_ready=1 -> event_valid pulses 1 cycle, x=100, y=300, pol=1, event_ts = counter value at the POL byte.
REQ-025 Send 0xFE in X_HI, then packet 00 0A 00 FE 00 -> cmd_status pulses once; event y=254 delivered with no cmd pulse.
REQ-026 Send packet 01 40 00 05 00 (x=320) -> no event; err_count=1.
REQ-027 Send 2 bytes, idle BYTE_TIMEOUT_CYCLES -> err_count=1, parser in X_HI; the next 5-byte packet decodes correctly.
REQ-028 Hold event_ready=0 and send FIFO_DEPTH+3 valid packets -> fifo_full=1, drop_count=3. Then raise event_ready -> FIFO_DEPTH events come out in order, stable while stalled.
REQ-029 Pull rst_n low after 3 bytes of a packet with 2 events queued -> outputs at reset values at once; the next full packet is decoded correctly.
